// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU and pmem handshake bundle for the 2-way cache controller
interface cache_control_if #(
  parameter int IDX_W = 3
);
  logic [IDX_W-1:0] index;
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;

  // Environment side: CPU request source plus physical memory responder.
  modport master (
    output index, mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  // Controller side.
  modport slave (
    input  index, mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// rtl/cache_control.sv - control FSM for the 2-way set-associative LC3B cache
// Optional hit/miss performance counters: define CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  cache_control_if.slave      bus,
  input  logic                tag_match0,
  input  logic                tag_match1,
  output logic                way_sel,
  output logic                data_write0,
  output logic                data_write1,
  output logic                tag_write0,
  output logic                tag_write1,
  output logic                data_src_sel,
  output logic                pmem_addr_sel,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0][NUM_SETS-1:0] valid;
  logic [1:0][NUM_SETS-1:0] dirty;
  logic [NUM_SETS-1:0]      lru;
  logic                     victim;

  logic req, is_write;
  logic hit0, hit1, hit, hit_way;
  logic miss_victim, victim_dirty;

  logic mem_resp_c, pmem_read_c, pmem_write_c;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;

  // Way 0 takes priority if both ways ever report a hit.
  assign hit0    = valid[0][bus.index] & tag_match0;
  assign hit1    = valid[1][bus.index] & tag_match1;
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;

  // Fill an empty way first; only evict by LRU when the set is full.
  assign miss_victim  = !valid[0][bus.index] ? 1'b0 :
                        !valid[1][bus.index] ? 1'b1 : lru[bus.index];
  assign victim_dirty = valid[miss_victim][bus.index] & dirty[miss_victim][bus.index];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_COMPARE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_COMPARE: begin
        if (req && !hit) begin
          state_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (bus.pmem_resp) begin
          state_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (bus.pmem_resp) begin
          state_next = S_COMPARE;
        end
      end
      default: state_next = S_COMPARE;
    endcase
  end

  always_comb begin
    mem_resp_c    = 1'b0;
    pmem_read_c   = 1'b0;
    pmem_write_c  = 1'b0;
    way_sel       = 1'b0;
    data_write0   = 1'b0;
    data_write1   = 1'b0;
    tag_write0    = 1'b0;
    tag_write1    = 1'b0;
    data_src_sel  = 1'b0;
    pmem_addr_sel = 1'b0;
    unique case (state)
      S_COMPARE: begin
        if (req && hit) begin
          mem_resp_c = 1'b1;
          way_sel    = hit_way;
          if (is_write) begin
            data_write0 = ~hit_way;
            data_write1 = hit_way;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write_c  = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim;
      end
      S_ALLOCATE: begin
        pmem_read_c = 1'b1;
        way_sel     = victim;
        if (bus.pmem_resp) begin
          data_write0  = ~victim;
          data_write1  = victim;
          tag_write0   = ~victim;
          tag_write1   = victim;
          data_src_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_resp   = mem_resp_c;
  assign bus.pmem_read  = pmem_read_c;
  assign bus.pmem_write = pmem_write_c;

  // Per-set metadata; the victim is frozen once we leave COMPARE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid  <= '0;
      dirty  <= '0;
      lru    <= '0;
      victim <= 1'b0;
    end else begin
      unique case (state)
        S_COMPARE: begin
          if (req) begin
            if (hit) begin
              lru[bus.index] <= ~hit_way;
              if (is_write) begin
                dirty[hit_way][bus.index] <= 1'b1;
              end
            end else begin
              victim <= miss_victim;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.pmem_resp) begin
            dirty[victim][bus.index] <= 1'b0;
          end
        end
        S_ALLOCATE: begin
          if (bus.pmem_resp) begin
            valid[victim][bus.index] <= 1'b1;
            dirty[victim][bus.index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      if (state == S_COMPARE && mem_resp_c && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_q <= hit_cnt_q + 16'h0001;
      end
      if (state == S_COMPARE && state_next != S_COMPARE && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'h0001;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule
